// File: rtl/stage_m.sv
// Memory stage: E/M pipeline register plus a single-outstanding req/ack data-memory port.
// Reports MemBusyM to the hazard unit while a memory op in M is still unacknowledged.
module stage_m #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] ALUResultE,
   input  logic [WIDTH-1:0] WriteDataE,
   input  logic [WIDTH-1:0] PCPlus4E,
   input  logic [4:0]       RdE,
   input  logic             RegWriteE,
   input  logic             MemWriteE,
   input  logic [1:0]       ResultSrcE,
   input  logic             armE,
   input  logic             StallM,
   input  logic             FlushM,
   output logic [WIDTH-1:0] ALUResultM,
   output logic [WIDTH-1:0] WriteDataM,
   output logic [WIDTH-1:0] PCPlus4M,
   output logic [4:0]       RdM,
   output logic             RegWriteM,
   output logic             MemWriteM,
   output logic             armM,
   output logic [1:0]       ResultSrcM,
   output logic [WIDTH-1:0] ReadDataM,
   output logic             MemBusyM,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [WIDTH-1:0] r_alu_result;
   logic [WIDTH-1:0] r_write_data;
   logic [WIDTH-1:0] r_pc_plus4;
   logic [4:0]       r_rd;
   logic             r_reg_write;
   logic             r_mem_write;
   logic             r_arm;
   logic [1:0]       r_result_src;
   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] r_rdq;
   logic [WIDTH-1:0] w_rdq_nxt;
   logic             w_memop;
   logic             w_busy;
   logic             w_advance;

   assign w_memop   = r_mem_write | (r_result_src == 2'b01);
   assign w_busy    = w_memop & ~mem_ack & (r_state != S_DONE);
   assign w_advance = ~StallM & ~w_busy;

   // E/M pipeline register: hold beats flush, flush loads an all-zero bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_alu_result <= '0;
         r_write_data <= '0;
         r_pc_plus4   <= '0;
         r_rd         <= 5'd0;
         r_reg_write  <= 1'b0;
         r_mem_write  <= 1'b0;
         r_arm        <= 1'b0;
         r_result_src <= 2'b00;
      end else if (w_advance) begin
         if (FlushM) begin
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc_plus4   <= '0;
            r_rd         <= 5'd0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_arm        <= 1'b0;
            r_result_src <= 2'b00;
         end else begin
            r_alu_result <= ALUResultE;
            r_write_data <= WriteDataE;
            r_pc_plus4   <= PCPlus4E;
            r_rd         <= RdE;
            r_reg_write  <= RegWriteE;
            r_mem_write  <= MemWriteE;
            r_arm        <= armE;
            r_result_src <= ResultSrcE;
         end
      end
   end

   // Handshake FSM; an ack that lands while held parks the data in rdq (DONE) so the op is never reissued
   always_comb begin
      w_state_nxt = r_state;
      w_rdq_nxt   = r_rdq;
      case (r_state)
         S_IDLE: begin
            if (w_memop) begin
               if (mem_ack) begin
                  if (StallM) begin
                     w_state_nxt = S_DONE;
                     w_rdq_nxt   = mem_rdata;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               w_rdq_nxt   = mem_rdata;
               w_state_nxt = StallM ? S_DONE : S_IDLE;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         S_DONE: begin
            w_state_nxt = StallM ? S_DONE : S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM state and captured load data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_rdq   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rdq   <= w_rdq_nxt;
      end
   end

   assign ALUResultM = r_alu_result;
   assign WriteDataM = r_write_data;
   assign PCPlus4M   = r_pc_plus4;
   assign RdM        = r_rd;
   assign RegWriteM  = r_reg_write;
   assign MemWriteM  = r_mem_write;
   assign armM       = r_arm;
   assign ResultSrcM = r_result_src;
   assign MemBusyM   = w_busy;
   assign mem_req    = w_memop & (r_state != S_DONE);
   assign mem_we     = r_mem_write;
   assign mem_addr   = r_alu_result;
   assign mem_wdata  = r_write_data;
   assign ReadDataM  = (r_state == S_DONE) ? r_rdq : mem_rdata;

endmodule

// File: tb/tb_stage_m.sv
// Scoreboard bench for stage_m: expected memory transactions are queued by the stimulus
// and popped by a monitor whenever the DUT completes a req/ack handshake.
module tb_stage_m;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } mem_exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
   logic [4:0]  RdE;
   logic        RegWriteE, MemWriteE, armE, StallM, FlushM;
   logic [1:0]  ResultSrcE;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M, ReadDataM;
   logic [4:0]  RdM;
   logic        RegWriteM, MemWriteM, armM, MemBusyM;
   logic [1:0]  ResultSrcM;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int       n_checks  = 0;
   int       n_errors  = 0;
   int       ack_count = 0;
   mem_exp_t mem_q[$];

   logic        prev_req, prev_ack, prev_we;
   logic [31:0] prev_addr, prev_wdata;

   stage_m #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
      .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
      .ResultSrcE(ResultSrcE), .armE(armE), .StallM(StallM), .FlushM(FlushM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
      .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .armM(armM),
      .ResultSrcM(ResultSrcM), .ReadDataM(ReadDataM), .MemBusyM(MemBusyM),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_e(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                        input logic [4:0] rd, input logic rw, input logic mw,
                        input logic [1:0] rs, input logic arm);
      ALUResultE = alu;
      WriteDataE = wd;
      PCPlus4E   = pc4;
      RdE        = rd;
      RegWriteE  = rw;
      MemWriteE  = mw;
      ResultSrcE = rs;
      armE       = arm;
   endtask

   // Monitor: pop the scoreboard on each completed handshake; check request stability while waiting
   always @(negedge clk) begin
      if (rst) begin
         if (mem_req && mem_ack) begin
            ack_count++;
            if (mem_q.size() == 0) begin
               chk("unexpected_txn", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               mem_exp_t e;
               e = mem_q.pop_front();
               chk("txn_addr", {32'd0, mem_addr}, {32'd0, e.addr});
               chk("txn_we", {63'd0, mem_we}, {63'd0, e.we});
               chk("txn_wdata", {32'd0, mem_wdata}, {32'd0, e.wdata});
               if (!e.we) chk("txn_rdata", {32'd0, ReadDataM}, {32'd0, e.rdata});
            end
         end
         if (prev_req && !prev_ack && mem_req) begin
            chk("req_stable", {mem_we, mem_addr, mem_wdata[30:0]},
                {prev_we, prev_addr, prev_wdata[30:0]});
         end
      end
      prev_req   = mem_req & rst;
      prev_ack   = mem_ack;
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt;
      int acks0;
      rst = 1'b0; StallM = 1'b0; FlushM = 1'b0; mem_ack = 1'b0;
      mem_rdata = 32'h5555_AAAA;
      set_e(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);

      // Reset with random E inputs
      for (int i = 0; i < 3; i++) begin
         step();
         set_e($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
               2'($urandom), 1'($urandom));
      end
      @(negedge clk);
      chk("rst_data", {32'd0, ALUResultM | WriteDataM | PCPlus4M}, 64'd0);
      chk("rst_ctrl", {54'd0, RdM, RegWriteM, MemWriteM, armM, ResultSrcM}, 64'd0);
      chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
      chk("rst_busy", {63'd0, MemBusyM}, 64'd0);
      chk("rst_rdata_pass", {32'd0, ReadDataM}, 64'h5555_AAAA);

      // Release: first edge captures
      set_e(32'h10, 32'd0, 32'd0, 5'd5, 1'b0, 1'b0, 2'b00, 1'b0);
      rst = 1'b1;
      step();
      chk("rel_alu", {32'd0, ALUResultM}, 64'h10);
      chk("rel_rd", {59'd0, RdM}, 64'd5);

      // ALU op
      set_e(32'h1234, 32'd0, 32'h1238, 5'd4, 1'b1, 1'b0, 2'b00, 1'b1);
      step();
      chk("alu_result", {32'd0, ALUResultM}, 64'h1234);
      chk("alu_regwrite", {63'd0, RegWriteM}, 64'd1);
      chk("alu_pc4_arm", {31'd0, PCPlus4M, armM}, {31'd0, 32'h1238, 1'b1});
      chk("alu_no_req", {63'd0, mem_req}, 64'd0);

      // Zero-wait load
      set_e(32'h100, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 2'b01, 1'b0);
      mem_q.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'd0, rdata: 32'hCAFE_F00D});
      step();
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      set_e(32'h55, 32'd0, 32'd0, 5'd1, 1'b1, 1'b0, 2'b00, 1'b0);
      @(negedge clk);
      chk("zw_req", {63'd0, mem_req}, 64'd1);
      chk("zw_busy", {63'd0, MemBusyM}, 64'd0);
      chk("zw_rdata", {32'd0, ReadDataM}, 64'hCAFE_F00D);
      step();
      mem_ack = 1'b0;
      chk("zw_advance", {32'd0, ALUResultM}, 64'h55);
      chk("zw_req_after", {63'd0, mem_req}, 64'd0);

      // 3-wait store
      set_e(32'h200, 32'hA5A5_A5A5, 32'd0, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0);
      mem_q.push_back('{addr: 32'h200, we: 1'b1, wdata: 32'hA5A5_A5A5, rdata: 32'd0});
      step();
      set_e(32'h66, 32'd0, 32'd0, 5'd2, 1'b1, 1'b0, 2'b00, 1'b0);
      busy_cnt = 0;
      acks0 = ack_count;
      for (int c = 0; c < 4; c++) begin
         mem_ack = (c == 3);
         @(negedge clk);
         if (MemBusyM) busy_cnt++;
         chk("st_held", {32'd0, ALUResultM}, 64'h200);
         step();
      end
      mem_ack = 1'b0;
      chk("st_busy_cycles", 64'(busy_cnt), 64'd3);
      chk("st_one_ack", 64'(ack_count - acks0), 64'd1);
      chk("st_advance", {32'd0, ALUResultM}, 64'h66);
      chk("st_no_req", {63'd0, mem_req}, 64'd0);

      // Load acked while StallM=1
      set_e(32'h300, 32'd0, 32'd0, 5'd7, 1'b1, 1'b0, 2'b01, 1'b0);
      mem_q.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'd0, rdata: 32'h77});
      step();
      set_e(32'h99, 32'd0, 32'd0, 5'd8, 1'b1, 1'b0, 2'b00, 1'b0);
      acks0 = ack_count;
      step();
      StallM = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h77;
      step();
      mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         FlushM = (c == 1);
         StallM = (c < 2);
         @(negedge clk);
         chk("stl_no_req", {63'd0, mem_req}, 64'd0);
         chk("stl_rdata", {32'd0, ReadDataM}, 64'h77);
         chk("stl_held", {32'd0, ALUResultM}, 64'h300);
         step();
      end
      FlushM = 1'b0;
      chk("stl_one_ack", 64'(ack_count - acks0), 64'd1);
      chk("stl_advance", {32'd0, ALUResultM}, 64'h99);

      // Flush loads a bubble
      set_e(32'h500, 32'h1, 32'h2, 5'd6, 1'b1, 1'b1, 2'b01, 1'b1);
      FlushM = 1'b1;
      step();
      FlushM = 1'b0;
      set_e(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
      chk("flush_data", {32'd0, ALUResultM | WriteDataM | PCPlus4M}, 64'd0);
      chk("flush_ctrl", {54'd0, RdM, RegWriteM, MemWriteM, armM, ResultSrcM}, 64'd0);
      chk("flush_no_req", {63'd0, mem_req}, 64'd0);

      // Reset in the second wait cycle
      set_e(32'h400, 32'd0, 32'd0, 5'd9, 1'b1, 1'b0, 2'b01, 1'b0);
      step();
      set_e(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
      acks0 = ack_count;
      step();
      step();
      chk("rw_req_before", {63'd0, mem_req}, 64'd1);
      #1 rst = 1'b0;
      #1 chk("rw_req_drop", {63'd0, mem_req}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      step();
      mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
      @(negedge clk);
      chk("rw_ack_ignored_req", {63'd0, mem_req | MemBusyM}, 64'd0);
      step();
      mem_ack = 1'b0;
      chk("rw_no_txn", 64'(ack_count - acks0), 64'd0);
      chk("rw_no_load", {61'd0, RegWriteM, ResultSrcM}, 64'd0);
      chk("scoreboard_empty", 64'(mem_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
